alu_md: RTL and testbench
=========================

// Module: alu_md
// PURPOSE
//  Parametrised execute-stage ALU with iterative multiply/divide unit and HI/LO result pair.
//  Single-cycle ops (logic, add/sub, compares, shifts) return registered one cycle after accept.
//  MULT/MULTU/DIV/DIVU run WIDTH iterations, stall the stage via in_ready and write HI/LO.
//  Sits between ID/EX operand muxing and the EX/MEM register; the hazard unit consumes busy.
// PARAMETERS
//  WIDTH   32   operand/result width; even, >=8; shift amount = b[$clog2(WIDTH)-1:0]
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  in_valid     in   1      op/a/b valid this cycle
//  in_ready     out  1      block can accept; transfer = in_valid & in_ready
//  op           in   4      operation code (see BEHAVIOUR)
//  a            in   WIDTH  operand A (rs)
//  b            in   WIDTH  operand B (rt / immediate)
//  out_valid    out  1      one-cycle pulse: result/zero (and hi/lo for mul/div) valid
//  result       out  WIDTH  registered result; LO for mul/div
//  zero         out  1      (result == 0), registered with result
//  hi           out  WIDTH  HI register (mul high half / div remainder)
//  lo           out  WIDTH  LO register (mul low half / div quotient)
//  busy         out  1      mul/div iteration in progress (= ~in_ready)
//  div_by_zero  out  1      pulses with out_valid when a DIV/DIVU had b == 0
// BEHAVIOUR
//  Reset (async, rst_n=0): result, hi, lo = 0; zero = 1; out_valid, busy, div_by_zero = 0;
//   in_ready = 1; FSM -> IDLE; counter = 0. Reset mid-iteration aborts it; HI/LO not updated.
//  Op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1000 XOR, 1001 NOR,
//   1010 SLTU, 1011 SLL, 1100 SRL, 1101 SRA, 0011 MULT, 0100 MULTU, 0101 DIV, 1111 DIVU.
//  Add/sub wrap modulo 2^WIDTH; no overflow trap. SLT true signed: (a-b) sign XOR overflow.
//  SLT/SLTU result = {WIDTH-1 zeros, bit}. SRA replicates a[WIDTH-1]; shift amount from b.
//  FSM: IDLE, MUL, DIV, FIX.
//   IDLE: transfer of single-cycle op -> result/zero registered, out_valid=1 next cycle; stay IDLE;
//    back-to-back accepts every cycle. HI/LO unchanged.
//   IDLE: transfer of MULT/MULTU -> MUL; DIV/DIVU with b!=0 -> DIV; in_ready drops next cycle.
//    Signed ops latch magnitudes |a|,|b| and result sign (MULT: a^b; DIV: quot a^b, rem a).
//   MUL: shift-add, one multiplier bit per cycle, counter 0..WIDTH-1; at WIDTH-1 -> FIX.
//   DIV: restoring, one quotient bit per cycle, counter 0..WIDTH-1; at WIDTH-1 -> FIX.
//   FIX: apply two's-complement sign correction, write HI/LO, result = LO, out_valid=1 -> IDLE.
//  Latency accept->out_valid: 1 cycle single ops; WIDTH+1 cycles mul/div (incl. FIX).
//  in_ready = 1 only in IDLE; in_valid while busy is ignored (no queueing).
//  DIV/DIVU with b == 0: no iteration; next cycle hi = a, lo = {WIDTH{1'b1}}, result = lo,
//   div_by_zero = 1, out_valid = 1; stay IDLE.
//  DIV most-negative / -1: quotient wraps to most-negative, remainder 0 (no trap).
//  out_valid and div_by_zero are single-cycle pulses; result/zero hold until next completion.
//  Operands are latched at accept; later changes to a/b/op do not affect an in-flight op.
// TESTING
//  ADD 0x7FFFFFFF+1 -> result 0x80000000, zero=0, out_valid 1 cycle after accept; SUB 5-5 -> zero=1.
//  SLT a=0x80000000,b=1 -> 1; SLTU same -> 0; SRA 0x80000000 by 4 -> 0xF8000000.
//  MULT a=-3,b=7 -> busy 32 cycles, out_valid at cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//  DIV a=-7,b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> lo=0xFFFFFFFF, hi=7, div_by_zero=1.
//  in_valid held with ADD during MULTU -> not accepted until in_ready=1; issued exactly once after.
//  rst_n low at iteration 10 of DIVU -> all outputs reset values immediately; next op runs clean.

Source files
------------

// File: rtl/alu_md.sv
// alu_md: execute-stage ALU with an iterative shift-add multiplier,
// a restoring divider and a HI/LO result register pair.
module alu_md #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_MULT  = 4'b0011;
  localparam logic [3:0] OP_MULTU = 4'b0100;
  localparam logic [3:0] OP_DIV   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_XOR   = 4'b1000;
  localparam logic [3:0] OP_NOR   = 4'b1001;
  localparam logic [3:0] OP_SLTU  = 4'b1010;
  localparam logic [3:0] OP_SLL   = 4'b1011;
  localparam logic [3:0] OP_SRL   = 4'b1100;
  localparam logic [3:0] OP_SRA   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

  state_e               state_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opb_q;
  logic [SW-1:0]        cnt_q;
  logic                 neg_lo_q;
  logic                 neg_hi_q;
  logic                 is_div_q;
  logic [WIDTH-1:0]     result_q;
  logic                 zero_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 out_valid_q;
  logic                 dbz_q;

  logic [WIDTH-1:0]     alu_d;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [2*WIDTH-1:0]   mul_init_d;
  logic [2*WIDTH-1:0]   div_init_d;
  logic [2*WIDTH-1:0]   mul_step_d;
  logic [2*WIDTH-1:0]   div_step_d;
  logic [WIDTH-1:0]     fix_hi_d;
  logic [WIDTH-1:0]     fix_lo_d;
  logic                 is_mul_op;
  logic                 is_div_op;
  logic                 is_signed_op;
  logic                 b_is_zero;

  // One shift-add step: low half holds the remaining multiplier bits,
  // high half accumulates; the product shifts in from the top.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   mcand);
    logic [WIDTH:0] sum;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    return {sum, acc[WIDTH-1:1]};
  endfunction

  // One restoring-division step: high half is the partial remainder,
  // low half shifts dividend bits out and quotient bits in.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   dvsr);
    logic [WIDTH:0] rsh;
    logic [WIDTH:0] diff;
    rsh  = acc[2*WIDTH-1:WIDTH-1];
    diff = rsh - {1'b0, dvsr};
    if (diff[WIDTH]) return {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    return {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  endfunction

  // Single-cycle ALU result, operand magnitudes and iteration/fix-up datapath.
  always_comb begin
    logic [WIDTH-1:0]   diff;
    logic               ovf;
    logic [SW-1:0]      sh;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quot;

    sh   = b[SW-1:0];
    diff = a - b;
    ovf  = (a[WIDTH-1] ^ b[WIDTH-1]) & (diff[WIDTH-1] ^ a[WIDTH-1]);

    alu_d = '0;
    case (op)
      OP_AND:  alu_d = a & b;
      OP_OR:   alu_d = a | b;
      OP_ADD:  alu_d = a + b;
      OP_SUB:  alu_d = diff;
      OP_SLT:  alu_d = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ovf};
      OP_XOR:  alu_d = a ^ b;
      OP_NOR:  alu_d = ~(a | b);
      OP_SLTU: alu_d = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  alu_d = a << sh;
      OP_SRL:  alu_d = a >> sh;
      OP_SRA:  alu_d = $unsigned($signed(a) >>> sh);
      default: alu_d = '0;
    endcase

    is_mul_op    = (op == OP_MULT) || (op == OP_MULTU);
    is_div_op    = (op == OP_DIV) || (op == OP_DIVU);
    is_signed_op = (op == OP_MULT) || (op == OP_DIV);
    b_is_zero    = (b == '0);

    abs_a = (is_signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
    abs_b = (is_signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // Iteration 0 is performed on the accept edge, so MUL/DIV only
    // need counter values 1..WIDTH-1.
    mul_init_d = mul_step({{WIDTH{1'b0}}, abs_b}, abs_a);
    div_init_d = div_step({{WIDTH{1'b0}}, abs_a}, abs_b);
    mul_step_d = mul_step(acc_q, opb_q);
    div_step_d = div_step(acc_q, opb_q);

    prod_neg = ~acc_q + 1'b1;
    rem      = acc_q[2*WIDTH-1:WIDTH];
    quot     = acc_q[WIDTH-1:0];
    if (is_div_q) begin
      fix_hi_d = neg_hi_q ? (~rem + 1'b1) : rem;
      fix_lo_d = neg_lo_q ? (~quot + 1'b1) : quot;
    end else begin
      fix_hi_d = neg_lo_q ? prod_neg[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      fix_lo_d = neg_lo_q ? prod_neg[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end
  end

  // Control FSM with registered result, HI/LO and completion pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      opb_q       <= '0;
      cnt_q       <= '0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
      is_div_q    <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      hi_q        <= '0;
      lo_q        <= '0;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (is_mul_op) begin
              state_q  <= MUL;
              acc_q    <= mul_init_d;
              opb_q    <= abs_a;
              neg_lo_q <= is_signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_hi_q <= 1'b0;
              is_div_q <= 1'b0;
              cnt_q    <= SW'(1);
            end else if (is_div_op && !b_is_zero) begin
              state_q  <= DIV;
              acc_q    <= div_init_d;
              opb_q    <= abs_b;
              neg_lo_q <= is_signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_hi_q <= is_signed_op & a[WIDTH-1];
              is_div_q <= 1'b1;
              cnt_q    <= SW'(1);
            end else if (is_div_op) begin
              hi_q        <= a;
              lo_q        <= '1;
              result_q    <= '1;
              zero_q      <= 1'b0;
              out_valid_q <= 1'b1;
              dbz_q       <= 1'b1;
            end else begin
              result_q    <= alu_d;
              zero_q      <= (alu_d == '0);
              out_valid_q <= 1'b1;
            end
          end
        end
        MUL: begin
          acc_q <= mul_step_d;
          if (cnt_q == SW'(WIDTH-1)) begin
            state_q <= FIX;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DIV: begin
          acc_q <= div_step_d;
          if (cnt_q == SW'(WIDTH-1)) begin
            state_q <= FIX;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FIX: begin
          hi_q        <= fix_hi_d;
          lo_q        <= fix_lo_d;
          result_q    <= fix_lo_d;
          zero_q      <= (fix_lo_d == '0);
          out_valid_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign zero        = zero_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: directed vectors for alu_md, checked against an arithmetic
// reference model every cycle plus hand-computed literal expectations.
module tb_alu_md;

  localparam int W = 32;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_MULT  = 4'b0011;
  localparam logic [3:0] OP_MULTU = 4'b0100;
  localparam logic [3:0] OP_DIV   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_XOR   = 4'b1000;
  localparam logic [3:0] OP_NOR   = 4'b1001;
  localparam logic [3:0] OP_SLTU  = 4'b1010;
  localparam logic [3:0] OP_SLL   = 4'b1011;
  localparam logic [3:0] OP_SRL   = 4'b1100;
  localparam logic [3:0] OP_SRA   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1111;

  typedef struct {
    int unsigned  due;
    logic [W-1:0] res;
    logic [W-1:0] hiV;
    logic [W-1:0] loV;
    logic         updHiLo;
    logic         dbz;
  } exp_t;

  logic         clk;
  logic         rstN;
  logic         inValid;
  logic         inReady;
  logic [3:0]   opIn;
  logic [W-1:0] aIn;
  logic [W-1:0] bIn;
  logic         outValid;
  logic [W-1:0] result;
  logic         zero;
  logic [W-1:0] hiOut;
  logic [W-1:0] loOut;
  logic         busy;
  logic         divByZero;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          busyLeft = 0;
  exp_t        pq[$];
  exp_t        newExp;
  bit          newLong;
  exp_t        curExp;
  logic [W-1:0] holdRes;
  logic [W-1:0] holdHi;
  logic [W-1:0] holdLo;
  logic         holdZero;
  logic         expValid;
  logic         expDbz;
  int           lat;

  alu_md #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rstN),
    .in_valid(inValid),
    .in_ready(inReady),
    .op(opIn),
    .a(aIn),
    .b(bIn),
    .out_valid(outValid),
    .result(result),
    .zero(zero),
    .hi(hiOut),
    .lo(loOut),
    .busy(busy),
    .div_by_zero(divByZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%h expected=0x%h cycle=%0d", name, actual, expected, cyc);
    end
  endtask

  // What an accepted op must produce, from plain wide arithmetic.
  function automatic exp_t predict(input logic [3:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, output bit isLong);
    exp_t e;
    longint sq;
    longint sr;
    logic [63:0] p;
    e.due = 0; e.res = '0; e.hiV = '0; e.loV = '0; e.updHiLo = 1'b0; e.dbz = 1'b0;
    isLong = 1'b0;
    case (o)
      OP_AND:  e.res = x & y;
      OP_OR:   e.res = x | y;
      OP_ADD:  e.res = x + y;
      OP_SUB:  e.res = x - y;
      OP_SLT:  e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      OP_XOR:  e.res = x ^ y;
      OP_NOR:  e.res = ~(x | y);
      OP_SLTU: e.res = (x < y) ? 32'd1 : 32'd0;
      OP_SLL:  e.res = x << y[4:0];
      OP_SRL:  e.res = x >> y[4:0];
      OP_SRA:  e.res = $unsigned($signed(x) >>> y[4:0]);
      OP_MULT: begin
        sq = longint'($signed(x)) * longint'($signed(y));
        p = sq;
        e.hiV = p[63:32]; e.loV = p[31:0]; e.updHiLo = 1'b1; isLong = 1'b1;
      end
      OP_MULTU: begin
        p = {32'b0, x} * {32'b0, y};
        e.hiV = p[63:32]; e.loV = p[31:0]; e.updHiLo = 1'b1; isLong = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        e.updHiLo = 1'b1;
        if (y == '0) begin
          e.hiV = x; e.loV = '1; e.dbz = 1'b1;
        end else begin
          isLong = 1'b1;
          if (o == OP_DIV) begin
            sq = longint'($signed(x)) / longint'($signed(y));
            sr = longint'($signed(x)) % longint'($signed(y));
            p = sq; e.loV = p[31:0];
            p = sr; e.hiV = p[31:0];
          end else begin
            e.loV = x / y;
            e.hiV = x % y;
          end
        end
      end
      default: e.res = '0;
    endcase
    if (e.updHiLo) e.res = e.loV;
    return e;
  endfunction

  // Reference model: accept when not busy, queue the expected completion.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pq.delete();
      busyLeft = 0;
    end else begin
      cyc = cyc + 1;
      if (busyLeft > 0) begin
        busyLeft = busyLeft - 1;
      end else if (inValid) begin
        newExp = predict(opIn, aIn, bIn, newLong);
        newExp.due = cyc + (newLong ? W : 0);
        if (newLong) busyLeft = W;
        pq.push_back(newExp);
      end
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    expValid = 1'b0;
    expDbz   = 1'b0;
    if (!rstN) begin
      holdRes = '0; holdZero = 1'b1; holdHi = '0; holdLo = '0;
    end else begin
      while (pq.size() > 0 && pq[0].due < cyc) curExp = pq.pop_front();
      if (pq.size() > 0 && pq[0].due == cyc) begin
        curExp   = pq.pop_front();
        expValid = 1'b1;
        expDbz   = curExp.dbz;
        holdRes  = curExp.res;
        holdZero = (curExp.res == '0);
        if (curExp.updHiLo) begin
          holdHi = curExp.hiV;
          holdLo = curExp.loV;
        end
      end
    end
    checkOutput("out_valid", outValid, expValid);
    checkOutput("result", result, holdRes);
    checkOutput("zero", zero, holdZero);
    checkOutput("hi", hiOut, holdHi);
    checkOutput("lo", loOut, holdLo);
    checkOutput("div_by_zero", divByZero, expDbz);
    checkOutput("in_ready", inReady, (busyLeft == 0));
    checkOutput("busy", busy, (busyLeft != 0));
  end

  // Present one op, hold in_valid until accepted, then scramble operands.
  task automatic applyStimulus(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    opIn = o; aIn = x; bIn = y; inValid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (inReady) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout actual=in_ready_low expected=accept op=%b", o);
      inValid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    inValid = 1'b0;
    aIn = x ^ 32'h5A5A_A5A5;
    bIn = y ^ 32'h0F0F_F0F0;
    opIn = OP_SUB;
  endtask

  // Count falling edges until out_valid; n is 0 when it never came.
  task automatic waitResult(output int n);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (outValid) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL result_timeout actual=no_out_valid expected=out_valid");
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence with literal expectations.
  initial begin
    rstN = 1'b0; inValid = 1'b0; opIn = '0; aIn = '0; bIn = '0;
    repeat (2) @(posedge clk);
    #2 rstN = 1'b1;
    @(negedge clk);
    checkOutput("rst_result", result, 32'h0);
    checkOutput("rst_zero", zero, 1'b1);
    checkOutput("rst_in_ready", inReady, 1'b1);

    applyStimulus(OP_ADD, 32'h7FFF_FFFF, 32'h1);
    waitResult(lat);
    checkOutput("add_latency", lat, 1);
    checkOutput("add_result", result, 32'h8000_0000);
    checkOutput("add_zero", zero, 1'b0);

    applyStimulus(OP_SUB, 32'd5, 32'd5);
    waitResult(lat);
    checkOutput("sub_zero", zero, 1'b1);

    applyStimulus(OP_SLT, 32'h8000_0000, 32'h1);
    waitResult(lat);
    checkOutput("slt_result", result, 32'h1);

    applyStimulus(OP_SLTU, 32'h8000_0000, 32'h1);
    waitResult(lat);
    checkOutput("sltu_result", result, 32'h0);

    applyStimulus(OP_SRA, 32'h8000_0000, 32'd4);
    waitResult(lat);
    checkOutput("sra_result", result, 32'hF800_0000);

    applyStimulus(OP_AND, 32'hF0F0_1234, 32'hFF00_FFFF);
    applyStimulus(OP_OR,  32'hF0F0_0000, 32'h0F00_000F);
    applyStimulus(OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000);
    applyStimulus(OP_NOR, 32'h0000_FFFF, 32'h00FF_0000);
    applyStimulus(OP_SLL, 32'h0000_0001, 32'd31);
    applyStimulus(OP_SRL, 32'h8000_0000, 32'd31);
    applyStimulus(OP_SLL, 32'h0000_0003, 32'h0000_0025);
    applyStimulus(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0000);
    waitResult(lat);
    checkOutput("slt_neg_result", result, 32'h1);

    applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    waitResult(lat);
    checkOutput("mult_latency", lat, 33);
    checkOutput("mult_hi", hiOut, 32'hFFFF_FFFF);
    checkOutput("mult_lo", loOut, 32'hFFFF_FFEB);
    checkOutput("mult_result", result, 32'hFFFF_FFEB);

    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitResult(lat);
    checkOutput("multu_hi", hiOut, 32'hFFFF_FFFE);
    checkOutput("multu_lo", loOut, 32'h0000_0001);

    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    waitResult(lat);
    checkOutput("div_latency", lat, 33);
    checkOutput("div_lo", loOut, 32'hFFFF_FFFD);
    checkOutput("div_hi", hiOut, 32'hFFFF_FFFF);

    applyStimulus(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    waitResult(lat);
    checkOutput("div_negb_lo", loOut, 32'hFFFF_FFFD);
    checkOutput("div_negb_hi", hiOut, 32'h0000_0001);

    applyStimulus(OP_DIVU, 32'd7, 32'd0);
    waitResult(lat);
    checkOutput("dbz_latency", lat, 1);
    checkOutput("dbz_lo", loOut, 32'hFFFF_FFFF);
    checkOutput("dbz_hi", hiOut, 32'h0000_0007);
    checkOutput("dbz_flag", divByZero, 1'b1);

    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitResult(lat);
    checkOutput("divmin_lo", loOut, 32'h8000_0000);
    checkOutput("divmin_hi", hiOut, 32'h0000_0000);

    applyStimulus(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    applyStimulus(OP_ADD, 32'd3, 32'd4);
    waitResult(lat);
    checkOutput("held_add_result", result, 32'd7);
    checkOutput("held_add_hi", hiOut, 32'h1);
    repeat (5) @(negedge clk);

    applyStimulus(OP_DIVU, 32'hFFFF_0000, 32'd3);
    repeat (10) @(posedge clk);
    #2 rstN = 1'b0;
    @(negedge clk);
    checkOutput("midrst_result", result, 32'h0);
    checkOutput("midrst_zero", zero, 1'b1);
    checkOutput("midrst_hi", hiOut, 32'h0);
    checkOutput("midrst_busy", busy, 1'b0);
    @(posedge clk);
    #2 rstN = 1'b1;

    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    waitResult(lat);
    checkOutput("postrst_latency", lat, 33);
    checkOutput("postrst_lo", loOut, 32'd14);
    checkOutput("postrst_hi", hiOut, 32'd2);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
